// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter that merges the LSU load and store request channels onto
// the single valid/ready data-cache port, with completion pulses and debug stats.
module lsu_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ADDR_SHIFT = 0,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_req,
  input  logic [ADDR_W-1:0]   load_addr,
  output logic [DATA_W-1:0]   load_data,
  output logic                load_complete,
  input  logic                store_req,
  input  logic [ADDR_W-1:0]   store_addr,
  input  logic [DATA_W-1:0]   store_data,
  output logic                store_complete,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  input  logic                stats_clr,
  output logic                busy,
  output logic [CNT_W-1:0]    n_loads,
  output logic [CNT_W-1:0]    n_stores,
  output logic                timeout_flag
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD_ISSUE, STORE_ISSUE, DONE} state_t;
  typedef enum logic {GRANT_LOAD, GRANT_STORE} chan_t;

  state_t              state_q, state_d;
  chan_t               last_q, last_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_d;
  logic [DATA_W-1:0]   load_data_d;
  logic                load_complete_d;
  logic                store_complete_d;
  logic                busy_d;
  logic [CNT_W-1:0]    n_loads_d;
  logic [CNT_W-1:0]    n_stores_d;
  logic                timeout_flag_d;

  logic                grant_load;
  logic                grant_store;

  // A tie goes to whichever channel did not receive the previous grant.
  assign grant_load  = load_req && (!store_req || last_q == GRANT_STORE);
  assign grant_store = store_req && !grant_load;

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    wait_d           = wait_q;
    mem_valid_d      = mem_valid;
    mem_addr_d       = mem_addr;
    mem_wdata_d      = mem_wdata;
    mem_wstrb_d      = mem_wstrb;
    load_data_d      = load_data;
    load_complete_d  = 1'b0;
    store_complete_d = 1'b0;
    n_loads_d        = n_loads;
    n_stores_d       = n_stores;
    timeout_flag_d   = timeout_flag;

    unique case (state_q)
      IDLE: begin
        if (grant_load) begin
          state_d     = LOAD_ISSUE;
          last_d      = GRANT_LOAD;
          wait_d      = '0;
          mem_valid_d = 1'b1;
          mem_addr_d  = load_addr << ADDR_SHIFT;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end else if (grant_store) begin
          state_d     = STORE_ISSUE;
          last_d      = GRANT_STORE;
          wait_d      = '0;
          mem_valid_d = 1'b1;
          mem_addr_d  = store_addr << ADDR_SHIFT;
          mem_wdata_d = store_data;
          mem_wstrb_d = {STRB_W{1'b1}};
        end
      end

      LOAD_ISSUE, STORE_ISSUE: begin
        // The wait count saturates at TIMEOUT so the flag fires once per request.
        if (wait_q != WAIT_W'(TIMEOUT)) wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_W'(TIMEOUT - 1)) timeout_flag_d = 1'b1;
        if (mem_ready) begin
          state_d     = DONE;
          wait_d      = '0;
          mem_valid_d = 1'b0;
          mem_wstrb_d = '0;
          if (state_q == LOAD_ISSUE) begin
            load_data_d     = mem_rdata;
            load_complete_d = 1'b1;
            if (n_loads != {CNT_W{1'b1}}) n_loads_d = n_loads + 1'b1;
          end else begin
            store_complete_d = 1'b1;
            if (n_stores != {CNT_W{1'b1}}) n_stores_d = n_stores + 1'b1;
          end
        end
      end

      DONE: begin
        // Requester drops req on this edge; req is deliberately not sampled here.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Clearing has priority over a completion or timeout on the same edge.
    if (stats_clr) begin
      n_loads_d      = '0;
      n_stores_d     = '0;
      timeout_flag_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_q         <= GRANT_STORE;
      wait_q         <= '0;
      mem_valid      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      load_data      <= '0;
      load_complete  <= 1'b0;
      store_complete <= 1'b0;
      busy           <= 1'b0;
      n_loads        <= '0;
      n_stores       <= '0;
      timeout_flag   <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      wait_q         <= wait_d;
      mem_valid      <= mem_valid_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
      mem_wstrb      <= mem_wstrb_d;
      load_data      <= load_data_d;
      load_complete  <= load_complete_d;
      store_complete <= store_complete_d;
      busy           <= busy_d;
      n_loads        <= n_loads_d;
      n_stores       <= n_stores_d;
      timeout_flag   <= timeout_flag_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Self-checking bench for lsu_mem_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_lsu_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int ADDR_SHIFT = 2;
  localparam int TIMEOUT    = 8;
  localparam int CNT_W      = 2;
  localparam int STRB_W     = DATA_W / 8;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              load_req = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data;
  logic              load_complete;
  logic              store_req = 1'b0;
  logic [ADDR_W-1:0] store_addr = '0;
  logic [DATA_W-1:0] store_data = '0;
  logic              store_complete;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              stats_clr = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  n_loads;
  logic [CNT_W-1:0]  n_stores;
  logic              timeout_flag;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_SHIFT(ADDR_SHIFT),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_complete(load_complete),
    .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
    .store_complete(store_complete),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stats_clr(stats_clr), .busy(busy), .n_loads(n_loads), .n_stores(n_stores),
    .timeout_flag(timeout_flag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        lreq;
    logic [31:0] laddr;
    logic        sreq;
    logic [31:0] saddr;
    logic [31:0] sdata;
    logic        ready;
    logic [31:0] rdata;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_lc;
    logic        e_sc;
    logic        e_busy;
    logic [31:0] e_ldata;
    logic [1:0]  e_nl;
    logic [1:0]  e_ns;
  } vec_t;

  function automatic vec_t mk(
    input logic lreq, input logic [31:0] laddr, input logic sreq,
    input logic [31:0] saddr, input logic [31:0] sdata, input logic ready,
    input logic [31:0] rdata, input logic e_valid, input logic [31:0] e_addr,
    input logic [31:0] e_wdata, input logic [3:0] e_wstrb, input logic e_lc,
    input logic e_sc, input logic e_busy, input logic [31:0] e_ldata,
    input logic [1:0] e_nl, input logic [1:0] e_ns);
    vec_t v;
    v.lreq = lreq; v.laddr = laddr; v.sreq = sreq; v.saddr = saddr; v.sdata = sdata;
    v.ready = ready; v.rdata = rdata; v.e_valid = e_valid; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_lc = e_lc; v.e_sc = e_sc;
    v.e_busy = e_busy; v.e_ldata = e_ldata; v.e_nl = e_nl; v.e_ns = e_ns;
    return v;
  endfunction

  // Reset with all inputs idle; checks the reset values; returns at posedge+1.
  task automatic do_reset();
    load_req = 0; store_req = 0; mem_ready = 0; stats_clr = 0;
    load_addr = '0; store_addr = '0; store_data = '0; mem_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_load_data", load_data, 0);
    check("rst_completes", {load_complete, store_complete}, 0);
    check("rst_busy", busy, 0);
    check("rst_counters", {n_loads, n_stores}, 0);
    check("rst_timeout_flag", timeout_flag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for mem_valid; returns at the negedge where it is seen.
  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_valid) begin ok = 1; break; end
    end
    if (!ok) check(name, 0, 1);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          model_en = 0;
  bit          seen_lc = 0, seen_sc = 0;
  int          m_owner;   // channel holding the memory port: 0 none, 1 load, 2 store
  int          m_pulse;   // channel whose completion is visible this cycle
  int          m_last;    // channel granted most recently
  int          m_wait;
  logic [31:0] m_addr, m_wdata, m_ldata;
  int          m_nl, m_ns;
  bit          m_tflag;

  always @(negedge clk) begin
    if (model_en) begin
      int winner;
      int new_pulse;
      int nreq;
      seen_lc = load_complete;
      seen_sc = store_complete;
      check("rnd_mem_valid", mem_valid, m_owner != 0);
      check("rnd_busy", busy, (m_owner != 0) || (m_pulse != 0));
      check("rnd_load_complete", load_complete, m_pulse == 1);
      check("rnd_store_complete", store_complete, m_pulse == 2);
      check("rnd_mem_wstrb", mem_wstrb, (m_owner == 2) ? 4'hF : 4'h0);
      if (m_owner != 0) begin
        check("rnd_mem_addr", mem_addr, m_addr);
        check("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      check("rnd_load_data", load_data, m_ldata);
      check("rnd_n_loads", n_loads, m_nl);
      check("rnd_n_stores", n_stores, m_ns);
      check("rnd_timeout_flag", timeout_flag, m_tflag);

      new_pulse = 0;
      if (m_owner != 0) begin
        m_wait++;
        if (m_wait == TIMEOUT) m_tflag = 1;
        if (mem_ready) begin
          new_pulse = m_owner;
          if (m_owner == 1) begin
            m_ldata = mem_rdata;
            if (m_nl < CMAX) m_nl++;
          end else if (m_ns < CMAX) m_ns++;
          m_owner = 0;
        end
      end else if (m_pulse == 0) begin
        nreq = int'(load_req) + int'(store_req);
        if (nreq == 2) winner = 3 - m_last;
        else if (load_req) winner = 1;
        else if (store_req) winner = 2;
        else winner = 0;
        if (winner != 0) begin
          m_owner = winner;
          m_last  = winner;
          m_wait  = 0;
          m_addr  = ((winner == 1) ? load_addr : store_addr) << ADDR_SHIFT;
          m_wdata = (winner == 2) ? store_data : 32'h0;
        end
      end
      if (stats_clr) begin
        m_nl = 0; m_ns = 0; m_tflag = 0;
      end
      m_pulse = new_pulse;
    end
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   grant_chan[$];
    int   grant_cyc[$];
    bit   prev_valid, found, sc_seen;
    int   ready_pct;

    #1;
    // ---- single load then single store (cycle-by-cycle table) ----
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0,            0, 0, 0, 0,              0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0,            1, 32'h40, 0, 0,         0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF, 1, 32'h40, 0, 0,         0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0,            0, 0, 0, 0,              1, 0, 1, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0,              0, 0, 0, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h20, 32'h12345678, 0, 0, 0, 0, 0, 0,              0, 0, 0, 32'hDEADBEEF, 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 1, 32'h20, 32'h12345678, 0, 0, 1, 32'h80, 32'h12345678, 4'hF,
                        0, 0, 1, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h20, 32'h12345678, 1, 32'hBAD0BAD0, 1, 32'h80, 32'h12345678, 4'hF,
                      0, 0, 1, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h20, 32'h12345678, 0, 0, 0, 0, 0, 0,              0, 1, 1, 32'hDEADBEEF, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0,              0, 0, 0, 32'hDEADBEEF, 1, 1));

    do_reset();
    foreach (vecs[i]) begin
      load_req = vecs[i].lreq; load_addr = vecs[i].laddr;
      store_req = vecs[i].sreq; store_addr = vecs[i].saddr; store_data = vecs[i].sdata;
      mem_ready = vecs[i].ready; mem_rdata = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("vec%0d_mem_valid", i), mem_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_mem_wstrb", i), mem_wstrb, vecs[i].e_wstrb);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
        check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      end
      check($sformatf("vec%0d_load_complete", i), load_complete, vecs[i].e_lc);
      check($sformatf("vec%0d_store_complete", i), store_complete, vecs[i].e_sc);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_load_data", i), load_data, vecs[i].e_ldata);
      check($sformatf("vec%0d_n_loads", i), n_loads, vecs[i].e_nl);
      check($sformatf("vec%0d_n_stores", i), n_stores, vecs[i].e_ns);
      @(posedge clk); #1;
    end

    // ---- both channels requesting continuously: strict alternation ----
    do_reset();
    load_req = 1; load_addr = 32'h1; store_req = 1; store_addr = 32'h2;
    store_data = 32'h55; mem_ready = 1;
    prev_valid = 0;
    for (int c = 0; c < 40 && grant_chan.size() < 4; c++) begin
      @(negedge clk);
      if (mem_valid && !prev_valid) begin
        grant_chan.push_back((mem_wstrb != 0) ? 2 : 1);
        grant_cyc.push_back(c);
      end
      prev_valid = mem_valid;
    end
    check("rr_grants_seen", grant_chan.size(), 4);
    foreach (grant_chan[i]) begin
      check($sformatf("rr_grant%0d_channel", i), grant_chan[i], (i % 2 == 0) ? 1 : 2);
      if (i > 0) check($sformatf("rr_grant%0d_spacing", i), grant_cyc[i] - grant_cyc[i-1], 3);
    end
    @(posedge clk); #1;

    // ---- timeout: ready withheld 20 wait cycles ----
    do_reset();
    load_req = 1; load_addr = 32'h5; mem_ready = 0;
    wait_valid("to_valid_timeout");
    for (int k = 0; k < 20; k++) begin
      check($sformatf("to_flag_wait%0d", k), timeout_flag, k >= 8);
      check($sformatf("to_valid_wait%0d", k), mem_valid, 1);
      @(posedge clk); #1;
      if (k == 19) mem_ready = 1;
      @(negedge clk);
    end
    check("to_valid_at_ready", mem_valid, 1);
    @(posedge clk); #1;
    mem_ready = 0;
    @(negedge clk);
    check("to_load_complete", load_complete, 1);
    check("to_flag_after_done", timeout_flag, 1);
    @(posedge clk); #1;
    load_req = 0; stats_clr = 1;
    @(posedge clk); #1;
    stats_clr = 0;
    @(negedge clk);
    check("to_flag_cleared", timeout_flag, 0);
    check("to_n_loads_cleared", n_loads, 0);
    @(posedge clk); #1;

    // ---- asynchronous reset during STORE_ISSUE ----
    do_reset();
    store_req = 1; store_addr = 32'h7; store_data = 32'hAA; mem_ready = 0;
    wait_valid("ar_valid_timeout");
    @(posedge clk); #1;
    @(negedge clk);
    check("ar_valid_before_reset", mem_valid, 1);
    #2;
    rst_n = 1'b0;
    store_req = 0;
    #1;
    check("ar_valid_dropped", mem_valid, 0);
    check("ar_busy_dropped", busy, 0);
    sc_seen = 0;
    repeat (3) begin
      @(negedge clk);
      sc_seen |= store_complete;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    sc_seen |= store_complete;
    check("ar_idle_after_release", busy, 0);
    @(posedge clk); #1;
    load_req = 1; load_addr = 32'h3; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sc_seen |= store_complete;
      if (load_complete) begin found = 1; break; end
    end
    check("ar_load_completed", found, 1);
    check("ar_load_data", load_data, 32'hCAFEF00D);
    check("ar_n_loads", n_loads, 1);
    check("ar_no_store_complete", sc_seen, 0);
    @(posedge clk); #1;
    load_req = 0;

    // ---- counter saturation and clear-vs-completion ----
    do_reset();
    mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      load_req = 1; load_addr = i; mem_rdata = 100 + i;
      found = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (load_complete) begin found = 1; break; end
      end
      check($sformatf("sat_load%0d_done", i), found, 1);
      check($sformatf("sat_load%0d_n_loads", i), n_loads, (i + 1 > CMAX) ? CMAX : i + 1);
      check($sformatf("sat_load%0d_data", i), load_data, 100 + i);
      @(posedge clk); #1;
      load_req = 0;
      @(posedge clk); #1;
    end
    load_req = 1; load_addr = 32'h9;
    wait_valid("clr_valid_timeout");
    stats_clr = 1;
    @(posedge clk); #1;
    stats_clr = 0;
    @(negedge clk);
    check("clr_load_complete", load_complete, 1);
    check("clr_wins_n_loads", n_loads, 0);
    @(posedge clk); #1;
    load_req = 0;

    // ---- randomized traffic against the reference model ----
    do_reset();
    m_owner = 0; m_pulse = 0; m_last = 2; m_wait = 0;
    m_addr = '0; m_wdata = '0; m_ldata = '0; m_nl = 0; m_ns = 0; m_tflag = 0;
    seen_lc = 0; seen_sc = 0;
    model_en = 1;
    ready_pct = 100;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) begin
        case ($urandom_range(3, 0))
          0: ready_pct = 100;
          1: ready_pct = 60;
          2: ready_pct = 25;
          default: ready_pct = 4;
        endcase
      end
      if (load_req && seen_lc) begin
        load_req = $urandom_range(1, 0);
        load_addr = $urandom;
      end else if (!load_req && $urandom_range(3, 0) == 0) begin
        load_req = 1; load_addr = $urandom;
      end
      if (store_req && seen_sc) begin
        store_req = $urandom_range(1, 0);
        store_addr = $urandom; store_data = $urandom;
      end else if (!store_req && $urandom_range(3, 0) == 0) begin
        store_req = 1; store_addr = $urandom; store_data = $urandom;
      end
      mem_ready = ($urandom_range(99, 0) < ready_pct);
      mem_rdata = $urandom;
      stats_clr = ($urandom_range(63, 0) == 0);
      @(posedge clk); #1;
    end
    model_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
Arbitrates the load and store request channels of the load/store unit onto the single native valid/ready port of the data cache. Grants one transaction at a time, round-robin between the two channels. Returns read data and a one-cycle completion pulse to the winning channel. Keeps per-channel transaction counters and a sticky timeout flag for debug.

Parameters:
ADDR_W, 32, address width of requester and memory ports (matches FE_ADDR_W)
DATA_W, 32, data width (matches FE_DATA_W)
ADDR_SHIFT, 0, left shift applied to the requester word address to form mem_addr (2 = byte addressing for 32-bit words)
TIMEOUT, 1024, cycles mem_valid may wait for mem_ready before timeout_flag sets
CNT_W, 16, width of the transaction counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
load_req  in  1  load request, level, held until load_complete
load_addr  in  ADDR_W  load word address, stable while load_req is high
load_data  out  DATA_W  registered read data, valid from the load_complete cycle onward
load_complete  out  1  one-cycle pulse, load finished
store_req  in  1  store request, level, held until store_complete
store_addr  in  ADDR_W  store word address, stable while store_req is high
store_data  in  DATA_W  write data, stable while store_req is high
store_complete  out  1  one-cycle pulse, store finished
mem_valid  out  1  memory request valid
mem_addr  out  ADDR_W  (latched addr << ADDR_SHIFT), truncated to ADDR_W
mem_wdata  out  DATA_W  latched store_data; 0 for loads
mem_wstrb  out  DATA_W/8  all ones for stores, all zeros for loads
mem_rdata  in  DATA_W  read data, valid when mem_ready=1
mem_ready  in  1  memory accepts/completes the current request
stats_clr  in  1  synchronous clear of counters and timeout_flag
busy  out  1  high whenever state != IDLE
n_loads  out  CNT_W  completed loads, saturating
n_stores  out  CNT_W  completed stores, saturating
timeout_flag  out  1  sticky, set when a wait reaches TIMEOUT

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=STORE (so load wins the first tie). All outputs 0: mem_valid, mem_addr, mem_wdata, mem_wstrb, load_data, both completes, busy, counters, timeout_flag. Wait counter=0. A reset mid-transaction drops mem_valid immediately; no completion is issued for the aborted request.
- FSM states: IDLE, LOAD_ISSUE, STORE_ISSUE, DONE. All outputs are registered.
- IDLE, only one req high: grant that channel. IDLE, both high: grant the channel != last_grant. On grant, on the same edge: latch addr (and data for stores), set mem_valid=1, set mem_wstrb, go to *_ISSUE, update last_grant.
- *_ISSUE: hold mem_valid/mem_addr/mem_wdata/mem_wstrb stable. The wait counter increments each cycle. If mem_ready=1 at an edge:
  - mem_valid<=0, mem_wstrb<=0.
  - For loads, load_data<=mem_rdata.
  - Assert the matching *_complete for exactly one cycle, go to DONE.
  - Increment the matching counter, saturating at all ones.
- Latency: with mem_ready tied high, req seen in cycle 0 gives mem_valid in cycle 1 and complete in cycle 2.
- DONE: complete pulse is high; requester req is still high. Do not sample req in DONE. Next edge: complete<=0, state=IDLE. Requesters drop req on that same edge, so the next grant needs a fresh req. Back-to-back throughput is one transaction per 3 cycles minimum.
- Timeout: when the wait counter reaches TIMEOUT-1 in *_ISSUE, timeout_flag<=1. The request is not aborted; mem_valid is held. The wait counter clears on leaving *_ISSUE.
- stats_clr: clears n_loads, n_stores and timeout_flag on the next edge. If a completion coincides with stats_clr, the clear wins (counter=0).
- req rising while not in IDLE: ignored until IDLE, with no loss because req is level-held.
- mem_ready high in IDLE or DONE: ignored.
- load_data holds its value until the next load completes.

Test Plan:
1. Single load: load_addr=0x10, ADDR_SHIFT=2, mem_ready on the cycle after mem_valid, mem_rdata=0xDEADBEEF -> mem_addr=0x40, mem_wstrb=0. load_complete pulses one cycle, 3 cycles after req; load_data=0xDEADBEEF; n_loads=1.
2. Single store: store_addr=0x20, store_data=0x12345678, mem_ready delayed 5 cycles -> mem_valid held high 6 cycles with stable addr/wdata, mem_wstrb=0xF. store_complete is one pulse; n_stores=1.
3. Simultaneous load_req and store_req after reset, both re-asserted continuously -> grant order load, store, load, store; no channel is granted twice in a row.
4. TIMEOUT=8, mem_ready held low 20 cycles then high -> timeout_flag=1 from wait cycle 8 and stays 1 after completion. stats_clr then clears it to 0.
5. Reset asserted while in STORE_ISSUE -> mem_valid=0 asynchronously, no store_complete. After release, state=IDLE and a new load completes normally.
6. Saturation with CNT_W=2: 5 loads -> n_loads=3 after the 3rd load and stays 3. stats_clr together with a completion leaves n_loads=0.
